// File: rtl/powlib_ipramx.sv
// powlib_ipramx: bus-addressable byte-laned RAM slave with credit flow control.
// Optional saturating errcnt port: define POWLIB_IPRAMX_ERRCNT_EN.
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif

module powlib_ipramx #(
   parameter string       ID     = "IPRAMX",
   parameter int          EDBG   = 0,
   parameter int          B_BPD  = 4,
   parameter int          B_AW   = `POWLIB_BW*B_BPD,
   parameter int unsigned B_BASE = 0,
   parameter int unsigned B_SIZE = 255,
   parameter int          IN_D   = 8,
   parameter int          OUT_D  = 8,
   localparam int         BW     = `POWLIB_BW,
   localparam int         OPW    = `POWLIB_OPW,
   localparam int         B_DW   = BW*B_BPD,
   localparam int         B_WW   = OPW+B_BPD+B_DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [B_AW-1:0] wraddr,
   input  logic [B_WW-1:0] wrdata,
   input  logic            wrvld,
   output logic            wrrdy,
   output logic [B_AW-1:0] rdaddr,
   output logic [B_WW-1:0] rddata,
   output logic            rdvld,
   input  logic            rdrdy
`ifdef POWLIB_IPRAMX_ERRCNT_EN
   ,
   output logic [15:0]     errcnt
`endif
);

   localparam int RAM_D = int'((B_SIZE+1)/B_BPD);
   localparam int IW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
   localparam int LW    = (B_BPD > 1) ? $clog2(B_BPD) : 0;
   localparam int IPW   = (IN_D > 1) ? $clog2(IN_D) : 1;
   localparam int ICW   = $clog2(IN_D+1);
   localparam int QPW   = (OUT_D > 1) ? $clog2(OUT_D) : 1;
   localparam int CW    = $clog2(OUT_D+1);
   localparam int FW    = B_AW+B_WW;
   localparam int QW    = B_AW+B_DW;

   localparam logic [OPW-1:0] OP_WRITE = OPW'(0);
   localparam logic [OPW-1:0] OP_READ  = OPW'(1);

   localparam logic [B_AW:0] LO = (B_AW+1)'(B_BASE);
   localparam logic [B_AW:0] HI = LO + (B_AW+1)'(B_SIZE);

   // Elaboration-time sanity checks on the configuration.
   if (B_BPD < 1 || (B_BPD & (B_BPD-1)) != 0) begin : g_bad_bpd
      $error("%s: B_BPD must be a power of two", ID);
   end
   if (B_AW > B_DW) begin : g_bad_aw
      $error("%s: B_AW must not exceed the data width", ID);
   end
   if ((B_BASE % B_BPD) != 0 || ((B_SIZE+1) % B_BPD) != 0) begin : g_bad_win
      $error("%s: RAM window must be word aligned", ID);
   end
   if (EDBG != 0 && EDBG != 1) begin : g_bad_edbg
      $error("%s: EDBG must be 0 or 1", ID);
   end

   logic [FW-1:0]   ifq [IN_D];
   logic [IPW-1:0]  iwp, irp;
   logic [ICW-1:0]  icnt;
   logic            push_i, vld_h, pop_h, rd_h, wr_h, rd_pop;
   logic [FW-1:0]   head;
   logic [B_AW-1:0] addr_h;
   logic [OPW-1:0]  op_h;
   logic [B_BPD-1:0] be_h;
   logic [B_DW-1:0] data_h;
   logic [CW-1:0]   credit;

   assign wrrdy  = icnt != ICW'(IN_D);
   assign push_i = wrvld && wrrdy;
   assign vld_h  = icnt != '0;
   assign head   = ifq[irp];
   assign addr_h = head[FW-1 -: B_AW];
   assign op_h   = head[B_WW-1 -: OPW];
   assign be_h   = head[B_DW +: B_BPD];
   assign data_h = head[B_DW-1:0];
   assign rd_h   = op_h == OP_READ;
   assign wr_h   = op_h == OP_WRITE;
   assign pop_h  = vld_h && (!rd_h || credit != '0);
   assign rd_pop = pop_h && rd_h;

   // Input FIFO storage.
   always_ff @(posedge clk) begin
      if (push_i) ifq[iwp] <= {wraddr, wrdata};
   end

   // Input FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iwp  <= '0;
         irp  <= '0;
         icnt <= '0;
      end else begin
         if (push_i)
            iwp <= (iwp == IPW'(IN_D-1)) ? '0 : iwp + 1'b1;
         if (pop_h)
            irp <= (irp == IPW'(IN_D-1)) ? '0 : irp + 1'b1;
         case ({push_i, pop_h})
            2'b10:   icnt <= icnt + 1'b1;
            2'b01:   icnt <= icnt - 1'b1;
            default: icnt <= icnt;
         endcase
      end
   end

   logic             s0_rd, s0_wr, hit0;
   logic [B_AW-1:0]  s0_addr;
   logic [B_BPD-1:0] s0_be;
   logic [B_DW-1:0]  s0_data;
   logic [B_AW:0]    ax;
   logic [IW-1:0]    idx0;

   // Stage 0 valid bits; discarded ops set neither.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_rd <= 1'b0;
         s0_wr <= 1'b0;
      end else begin
         s0_rd <= rd_pop;
         s0_wr <= pop_h && wr_h;
      end
   end

   // Stage 0 request payload.
   always_ff @(posedge clk) begin
      if (pop_h) begin
         s0_addr <= addr_h;
         s0_be   <= be_h;
         s0_data <= data_h;
      end
   end

   assign ax   = {1'b0, s0_addr};
   assign hit0 = (ax >= LO) && (ax <= HI);
   assign idx0 = IW'((ax - LO) >> LW);

   logic [B_DW-1:0] rdq;

   for (genvar g = 0; g < B_BPD; g++) begin : g_lane
      logic [BW-1:0] ram [RAM_D];
      logic [BW-1:0] q;
      // Lane write under its byte enable; read issued every cycle.
      always_ff @(posedge clk) begin
         if (s0_wr && hit0 && s0_be[g])
            ram[idx0] <= s0_data[g*BW +: BW];
         q <= ram[idx0];
      end
      assign rdq[g*BW +: BW] = q;
   end

   logic            s1_vld, s1_hit, s2_vld;
   logic [B_AW-1:0] s1_ret, s2_ret;
   logic [B_DW-1:0] s2_dat;

   // Stage 1/2 valid bits; only reads travel past stage 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end else begin
         s1_vld <= s0_rd;
         s2_vld <= s1_vld;
      end
   end

   // Stage 1/2 payload; misses return zero data.
   always_ff @(posedge clk) begin
      s1_hit <= hit0;
      s1_ret <= s0_data[B_AW-1:0];
      s2_ret <= s1_ret;
      s2_dat <= s1_hit ? rdq : '0;
   end

   logic [QW-1:0]   ofq [OUT_D];
   logic [QPW-1:0]  owp, orp;
   logic [CW-1:0]   ocnt;
   logic            o_pop;
   logic [B_DW-1:0] rd_d;

   assign rdvld  = ocnt != '0;
   assign o_pop  = rdvld && rdrdy;
   assign {rdaddr, rd_d} = ofq[orp];
   assign rddata = {OP_WRITE, {B_BPD{1'b1}}, rd_d};

   // Output FIFO storage; credits guarantee it never overflows.
   always_ff @(posedge clk) begin
      if (s2_vld) ofq[owp] <= {s2_ret, s2_dat};
   end

   // Output FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owp  <= '0;
         orp  <= '0;
         ocnt <= '0;
      end else begin
         if (s2_vld)
            owp <= (owp == QPW'(OUT_D-1)) ? '0 : owp + 1'b1;
         if (o_pop)
            orp <= (orp == QPW'(OUT_D-1)) ? '0 : orp + 1'b1;
         case ({s2_vld, o_pop})
            2'b10:   ocnt <= ocnt + 1'b1;
            2'b01:   ocnt <= ocnt - 1'b1;
            default: ocnt <= ocnt;
         endcase
      end
   end

   // Credits: one per free output slot, reserved at read pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit <= CW'(OUT_D);
      end else begin
         case ({rd_pop, o_pop})
            2'b10:   credit <= credit - 1'b1;
            2'b01:   credit <= credit + 1'b1;
            default: credit <= credit;
         endcase
      end
   end

`ifdef POWLIB_IPRAMX_ERRCNT_EN
   logic miss0;
   assign miss0 = (s0_rd || s0_wr) && !hit0;

   // Saturating count of out-of-range reads and writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         errcnt <= '0;
      else if (miss0 && errcnt != 16'hFFFF)
         errcnt <= errcnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_powlib_ipramx.sv
// tb_powlib_ipramx: vector table plus scoreboarded sequences
// for the powlib_ipramx RAM slave (B_BASE=0x100, 256-byte window).
module tb_powlib_ipramx;

   localparam logic [3:0] OP_W = 4'h0;
   localparam logic [3:0] OP_R = 4'h1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] wraddr;
   logic [39:0] wrdata;
   logic        wrvld;
   logic        wrrdy;
   logic [31:0] rdaddr;
   logic [39:0] rddata;
   logic        rdvld;
   logic        rdrdy;
`ifdef POWLIB_IPRAMX_ERRCNT_EN
   logic [15:0] errcnt;
`endif

   always #5 clk = ~clk;

   powlib_ipramx #(
      .B_BPD (4),
      .B_BASE(32'h100),
      .B_SIZE(255),
      .IN_D  (8),
      .OUT_D (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wraddr(wraddr),
      .wrdata(wrdata),
      .wrvld (wrvld),
      .wrrdy (wrrdy),
      .rdaddr(rdaddr),
      .rddata(rddata),
      .rdvld (rdvld),
      .rdrdy (rdrdy)
`ifdef POWLIB_IPRAMX_ERRCNT_EN
      ,
      .errcnt(errcnt)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   resp_t       exp_q[$];
   vec_t        tbl[13];
   logic [31:0] mdl[64];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          pops = 0;
   int          first_pop = 0;
   int          last_pop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Pop counter and response scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      resp_t e;
      if (rst && dut.pop_h) begin
         if (pops == 0) first_pop = cyc;
         last_pop = cyc;
         pops++;
      end
      if (rst && rdvld && rdrdy) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL resp_unexpected: got rdaddr %0h want none", rdaddr);
         end else begin
            e = exp_q.pop_front();
            chk("rdaddr", {32'h0, rdaddr}, {32'h0, e.addr});
            chk("rddata", {24'h0, rddata}, {24'h0, 4'h0, 4'hF, e.data});
         end
      end
   end

   function automatic logic in_win(input logic [31:0] a);
      return (a >= 32'h100) && (a <= 32'h1FF);
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'h100;
      return in_win(a) ? mdl[off[7:2]] : 32'h0;
   endfunction

   task automatic mwrite(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      logic [31:0] off;
      off = a - 32'h100;
      if (in_win(a))
         for (int b = 0; b < 4; b++)
            if (be[b]) mdl[off[7:2]][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp, output int acc);
      int n;
      resp_t r;
      n = 0;
      wraddr = a;
      wrdata = {op, be, d};
      wrvld  = 1'b1;
      @(negedge clk);
      while (!wrrdy && n < 200) begin
         n++;
         @(negedge clk);
      end
      acc = cyc;
      if (!wrrdy) begin
         n_chk++;
         $display("FAIL send_timeout: got wrrdy 0 want 1");
      end else if (op == OP_W) begin
         mwrite(a, d, be);
      end else if (op == OP_R) begin
         r.addr = d;
         r.data = exp;
         exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
      wrvld = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rdvld) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(exp_q.size()), 64'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc, k, n, stale;
      logic [31:0] a, d;

      tbl[0]  = '{OP_W,  32'h104, 4'hF, 32'hAABBCCDD, 32'h0};
      tbl[1]  = '{OP_W,  32'h104, 4'h5, 32'h11223344, 32'h0};
      tbl[2]  = '{OP_R,  32'h104, 4'h0, 32'h40,       32'hAA22CC44};
      tbl[3]  = '{OP_W,  32'h1FC, 4'hF, 32'h12345678, 32'h0};
      tbl[4]  = '{OP_R,  32'h1FC, 4'h0, 32'h44,       32'h12345678};
      tbl[5]  = '{OP_W,  32'h0FC, 4'hF, 32'hDEADBEEF, 32'h0};
      tbl[6]  = '{OP_R,  32'h200, 4'h0, 32'h48,       32'h0};
      tbl[7]  = '{OP_R,  32'h1FC, 4'h0, 32'h4C,       32'h12345678};
      tbl[8]  = '{4'h3,  32'h104, 4'hF, 32'h55555555, 32'h0};
      tbl[9]  = '{OP_R,  32'h104, 4'h0, 32'h50,       32'hAA22CC44};
      tbl[10] = '{OP_W,  32'h100, 4'hF, 32'h01020304, 32'h0};
      tbl[11] = '{OP_R,  32'h103, 4'h0, 32'h54,       32'h01020304};
      tbl[12] = '{OP_R,  32'h1FF, 4'h0, 32'h58,       32'h12345678};

      wraddr = '0;
      wrdata = '0;
      wrvld  = 1'b0;
      rdrdy  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_wrrdy", 64'(wrrdy), 64'h1);
      chk("rst_rdvld", 64'(rdvld), 64'h0);
      chk("rst_credit", 64'(dut.credit), 64'h8);
`ifdef POWLIB_IPRAMX_ERRCNT_EN
      chk("rst_errcnt", 64'(errcnt), 64'h0);
`endif
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++)
         send(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].exp, acc);
      drain("tbl_drain");
`ifdef POWLIB_IPRAMX_ERRCNT_EN
      chk("errcnt_oor", 64'(errcnt), 64'h2);
`endif

      // Latency: accept, pop, then 3 stages to the output FIFO.
      send(OP_R, 32'h104, 32'h60, 4'h0, mread(32'h104), acc);
      n = 0;
      while (!rdvld && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(cyc - acc), 64'd5);
      drain("lat_drain");

      // Credit stall: W/R pairs with the output blocked.
      rdrdy = 1'b0;
      pops = 0;
      for (int i = 0; i < 12; i++) begin
         a = 32'h180 + 32'(i*4);
         d = $urandom;
         send(OP_W, a, d, 4'hF, 32'h0, acc);
         send(OP_R, a, 32'h2000 + 32'(i), 4'h0, mread(a), acc);
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("stall_pops", 64'(pops), 64'd17);
      chk("stall_credit", 64'(dut.credit), 64'h0);
      chk("stall_rdvld", 64'(rdvld), 64'h1);
      @(posedge clk);
      #1 rdrdy = 1'b1;
      drain("stall_drain");

      // Reset with 3 reads in the pipe and 2 queued responses.
      rdrdy = 1'b0;
      send(OP_R, 32'h104, 32'h70, 4'h0, mread(32'h104), k);
      for (int i = 1; i < 5; i++)
         send(OP_R, 32'h1FC, 32'h70 + 32'(i), 4'h0, mread(32'h1FC), acc);
      n = 0;
      while (cyc < k + 6 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_queued", 64'(dut.ocnt), 64'h2);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rdvld", 64'(rdvld), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rdrdy = 1'b1;
      @(negedge clk);
      chk("mid_credit", 64'(dut.credit), 64'h8);
`ifdef POWLIB_IPRAMX_ERRCNT_EN
      chk("mid_errcnt", 64'(errcnt), 64'h0);
`endif
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (rdvld) stale++;
      end
      chk("mid_stale", 64'(stale), 64'h0);
      @(posedge clk);
      #1;
      send(OP_R, 32'h104, 32'h80, 4'h0, 32'hAA22CC44, acc);
      drain("mid_drain");

      // Throughput: 64 alternating writes and reads.
      pops = 0;
      for (int i = 0; i < 32; i++) begin
         a = 32'h100 + 32'(i*8);
         d = $urandom;
         send(OP_W, a, d, 4'hF, 32'h0, acc);
         send(OP_R, a, 32'h3000 + 32'(i), 4'h0, d, acc);
      end
      drain("tput_drain");
      chk("tput_pops", 64'(pops), 64'd64);
      chk("tput_span", 64'(last_pop - first_pop), 64'd63);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
